sprite_anim_renderer: RTL and testbench

- Parametrised animated-sprite pixel source for the raster video path, one instance per on-screen actor (player, each ghost).
- Stores DIRS x FRAMES bitmaps of W x H pixels at BPP bits per pixel in a writable row memory.
- Advances the animation frame on a vsync-based timer and latches the facing direction once per video frame.
- Returns a colour index plus a transparency flag for each (x, y) lookup, through a 2-stage pipeline.

---
 rtl/sprite_anim_renderer.sv | 110 +++++++++++
 tb/tb_sprite_anim_renderer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// Animated sprite pixel source: DIRS x FRAMES bitmaps in a row RAM, vsync-driven
// frame/direction update, and a 2-stage (row read, field select) lookup pipeline.
module sprite_anim_renderer #(
   parameter int unsigned W        = 16,
   parameter int unsigned H        = 16,
   parameter int unsigned BPP      = 2,
   parameter int unsigned FRAMES   = 2,
   parameter int unsigned DIRS     = 4,
   parameter int unsigned ANIM_DIV = 8,
   localparam int unsigned XW      = $clog2(W),
   localparam int unsigned YW      = $clog2(H),
   localparam int unsigned DW      = (DIRS > 1) ? $clog2(DIRS) : 1,
   localparam int unsigned FW      = (FRAMES > 1) ? $clog2(FRAMES) : 1,
   localparam int unsigned AW      = $clog2(DIRS * FRAMES * H),
   localparam int unsigned RW      = W * BPP
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          vsync,
   input  logic [DW-1:0] dir_in,
   input  logic          mirror_en,
   input  logic          pix_req,
   input  logic [XW-1:0] xin,
   input  logic [YW-1:0] yin,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [RW-1:0] wr_data,
   output logic [BPP-1:0] pix_out,
   output logic          pix_opaque,
   output logic          pix_out_valid,
   output logic [FW-1:0] anim_frame,
   output logic [DW-1:0] cur_dir
);

   localparam int unsigned DEPTH = DIRS * FRAMES * H;
   localparam int unsigned FBITS = $clog2(FRAMES);
   localparam int unsigned DVW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   logic [RW-1:0]  mem [DEPTH];
   logic [AW-1:0]  rd_addr;
   logic [DVW-1:0] div_cnt;

   logic           s1_valid;
   logic [XW-1:0]  s1_xe;
   logic [RW-1:0]  s1_row;
   logic [RW-1:0]  row_shift;
   logic [BPP-1:0] pix_sel;

   // Row address {cur_dir, anim_frame, yin}; FRAMES/DIRS of 1 contribute zero bits.
   assign rd_addr = (AW'(cur_dir) << (FBITS + YW)) | (AW'(anim_frame) << YW) | AW'(yin);

   // Row RAM: synchronous write, registered read; non-blocking gives read-before-write.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (pix_req) begin
         s1_row <= mem[rd_addr];
      end
   end

   // Stage 1 control: request valid and effective (possibly mirrored) column.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_xe    <= '0;
      end else begin
         s1_valid <= pix_req;
         if (pix_req) begin
            s1_xe <= mirror_en ? (XW'(W - 1) - xin) : xin;
         end
      end
   end

   assign row_shift = s1_row >> (32'(s1_xe) * BPP);
   assign pix_sel   = row_shift[BPP-1:0];

   // Stage 2: field select; outputs hold while no result is valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_out       <= '0;
         pix_opaque    <= 1'b0;
         pix_out_valid <= 1'b0;
      end else begin
         pix_out_valid <= s1_valid;
         if (s1_valid) begin
            pix_out    <= pix_sel;
            pix_opaque <= |pix_sel;
         end
      end
   end

   // Per-video-frame direction latch and animation step divider.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_dir    <= '0;
         anim_frame <= '0;
         div_cnt    <= '0;
      end else if (vsync) begin
         cur_dir <= dir_in;
         if (div_cnt == DVW'(ANIM_DIV - 1)) begin
            div_cnt    <= '0;
            anim_frame <= (FRAMES > 1) ? anim_frame + FW'(1) : '0;
         end else begin
            div_cnt <= div_cnt + DVW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed self-checking bench for sprite_anim_renderer (16x16, 2bpp, 2 frames, 4 dirs, div 8).
module tb_sprite_anim_renderer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vsync;
   logic [1:0]  dir_in;
   logic        mirror_en;
   logic        pix_req;
   logic [3:0]  xin;
   logic [3:0]  yin;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  pix_out;
   logic        pix_opaque;
   logic        pix_out_valid;
   logic [0:0]  anim_frame;
   logic [1:0]  cur_dir;

   int n_cmp = 0;
   int n_mis = 0;

   sprite_anim_renderer #(
      .W(16), .H(16), .BPP(2), .FRAMES(2), .DIRS(4), .ANIM_DIV(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .vsync(vsync), .dir_in(dir_in),
      .mirror_en(mirror_en), .pix_req(pix_req), .xin(xin), .yin(yin),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pix_out(pix_out), .pix_opaque(pix_opaque), .pix_out_valid(pix_out_valid),
      .anim_frame(anim_frame), .cur_dir(cur_dir)
   );

   always #5 clk = ~clk;

   task automatic write_row(input logic [1:0] d, input logic f, input logic [3:0] y,
                            input logic [31:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = {d, f, y}; wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_vsync();
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
   endtask

   task automatic lookup(input logic [3:0] x, input logic [3:0] y, input logic m,
                         output logic v, output logic [1:0] p, output logic o);
      @(negedge clk);
      pix_req = 1'b1; xin = x; yin = y; mirror_en = m;
      @(negedge clk);
      pix_req = 1'b0; mirror_en = 1'b0;
      @(negedge clk);
      v = pix_out_valid; p = pix_out; o = pix_opaque;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; vsync = 1'b0; dir_in = '0; mirror_en = 1'b0; pix_req = 1'b0;
      xin = '0; yin = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (pix_out !== 2'd0) begin n_mis++; $display("FAIL reset_pix_out got %0d exp 0", pix_out); end
      n_cmp++; if (pix_opaque !== 1'b0) begin n_mis++; $display("FAIL reset_opaque got %0b exp 0", pix_opaque); end
      n_cmp++; if (pix_out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %0b exp 0", pix_out_valid); end
      n_cmp++; if (anim_frame !== 1'b0) begin n_mis++; $display("FAIL reset_frame got %0d exp 0", anim_frame); end
      n_cmp++; if (cur_dir !== 2'd0) begin n_mis++; $display("FAIL reset_dir got %0d exp 0", cur_dir); end
   endtask

   // Back-to-back x=0..3 on row {0,0,3}=E4: valid for exactly cycles 2..5, then hold.
   task automatic test_back_to_back();
      logic [1:0] ep;
      write_row(2'd0, 1'b0, 4'd3, 32'h0000_00E4);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 5) begin
            ep = 2'(i - 2);
            n_cmp++; if (pix_out_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_valid cyc %0d got %0b exp 1", i, pix_out_valid); end
            n_cmp++; if (pix_out !== ep) begin n_mis++; $display("FAIL b2b_pix cyc %0d got %0d exp %0d", i, pix_out, ep); end
            n_cmp++; if (pix_opaque !== (ep != 2'd0)) begin n_mis++; $display("FAIL b2b_opaque cyc %0d got %0b exp %0b", i, pix_opaque, ep != 2'd0); end
         end else begin
            n_cmp++; if (pix_out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_idle cyc %0d got %0b exp 0", i, pix_out_valid); end
         end
         if (i >= 6) begin
            n_cmp++; if (pix_out !== 2'd3) begin n_mis++; $display("FAIL b2b_hold cyc %0d got %0d exp 3", i, pix_out); end
         end
         pix_req = (i < 4); xin = 4'(i); yin = 4'd3;
      end
      pix_req = 1'b0;
   endtask

   task automatic test_mirror();
      logic v, o; logic [1:0] p;
      lookup(4'd15, 4'd3, 1'b1, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd0 || o !== 1'b0) begin n_mis++; $display("FAIL mirror_x15 got v%0b p%0d o%0b exp v1 p0 o0", v, p, o); end
      lookup(4'd12, 4'd3, 1'b1, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd3 || o !== 1'b1) begin n_mis++; $display("FAIL mirror_x12 got v%0b p%0d o%0b exp v1 p3 o1", v, p, o); end
      lookup(4'd12, 4'd3, 1'b0, v, p, o);
      n_cmp++; if (p !== 2'd0) begin n_mis++; $display("FAIL nomirror_x12 got %0d exp 0", p); end
   endtask

   task automatic test_anim();
      logic v, o; logic [1:0] p;
      write_row(2'd0, 1'b1, 4'd3, 32'h0000_001B);
      repeat (7) pulse_vsync();
      n_cmp++; if (anim_frame !== 1'b0) begin n_mis++; $display("FAIL anim_after7 got %0d exp 0", anim_frame); end
      pulse_vsync();
      n_cmp++; if (anim_frame !== 1'b1) begin n_mis++; $display("FAIL anim_after8 got %0d exp 1", anim_frame); end
      lookup(4'd1, 4'd3, 1'b0, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd2) begin n_mis++; $display("FAIL anim_f1_read got v%0b p%0d exp v1 p2", v, p); end
      repeat (7) pulse_vsync();
      n_cmp++; if (anim_frame !== 1'b1) begin n_mis++; $display("FAIL anim_after15 got %0d exp 1", anim_frame); end
      pulse_vsync();
      n_cmp++; if (anim_frame !== 1'b0) begin n_mis++; $display("FAIL anim_after16 got %0d exp 0", anim_frame); end
      lookup(4'd1, 4'd3, 1'b0, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd1) begin n_mis++; $display("FAIL anim_f0_read got v%0b p%0d exp v1 p1", v, p); end
   endtask

   task automatic test_dir_latch();
      logic v, o; logic [1:0] p;
      write_row(2'd2, 1'b0, 4'd3, 32'h0000_0003);
      dir_in = 2'd2;
      repeat (2) @(negedge clk);
      n_cmp++; if (cur_dir !== 2'd0) begin n_mis++; $display("FAIL dir_before_vsync got %0d exp 0", cur_dir); end
      lookup(4'd0, 4'd3, 1'b0, v, p, o);
      n_cmp++; if (p !== 2'd0) begin n_mis++; $display("FAIL dir0_read got %0d exp 0", p); end
      pulse_vsync();
      n_cmp++; if (cur_dir !== 2'd2) begin n_mis++; $display("FAIL dir_after_vsync got %0d exp 2", cur_dir); end
      lookup(4'd0, 4'd3, 1'b0, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd3) begin n_mis++; $display("FAIL dir2_read got v%0b p%0d exp v1 p3", v, p); end
   endtask

   task automatic test_rbw();
      logic v, o; logic [1:0] p;
      write_row(2'd2, 1'b0, 4'd5, 32'h0000_0000);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = {2'd2, 1'b0, 4'd5}; wr_data = 32'hFFFF_FFFF;
      pix_req = 1'b1; xin = 4'd0; yin = 4'd5; mirror_en = 1'b0;
      @(negedge clk);
      wr_en = 1'b0; pix_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (pix_out_valid !== 1'b1 || pix_out !== 2'd0) begin n_mis++; $display("FAIL rbw_old got v%0b p%0d exp v1 p0", pix_out_valid, pix_out); end
      lookup(4'd0, 4'd5, 1'b0, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd3) begin n_mis++; $display("FAIL rbw_new got v%0b p%0d exp v1 p3", v, p); end
   endtask

   task automatic test_reset_mid_lookup();
      logic v, o; logic [1:0] p;
      @(negedge clk);
      pix_req = 1'b1; xin = 4'd3; yin = 4'd3; mirror_en = 1'b0;
      @(negedge clk);
      pix_req = 1'b0; reset_n = 1'b0; dir_in = 2'd0;
      @(negedge clk);
      n_cmp++; if (pix_out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_mid_valid got %0b exp 0", pix_out_valid); end
      n_cmp++; if (cur_dir !== 2'd0 || anim_frame !== 1'b0) begin n_mis++; $display("FAIL rst_mid_state got dir%0d f%0d exp dir0 f0", cur_dir, anim_frame); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (pix_out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_post_valid cyc %0d got %0b exp 0", i, pix_out_valid); end
      end
      lookup(4'd3, 4'd3, 1'b0, v, p, o);
      n_cmp++; if (v !== 1'b1 || p !== 2'd3 || o !== 1'b1) begin n_mis++; $display("FAIL rst_mem_kept got v%0b p%0d o%0b exp v1 p3 o1", v, p, o); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mirror();
      test_anim();
      test_dir_latch();
      test_rbw();
      test_reset_mid_lookup();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
